// File: rtl/add32_share_ctrl.sv
// add32_share_ctrl: round-robin share of one add32 datapath, 32-bit ops in one pass, 64-bit ops in two.
// Optional subtract support is enabled by defining ADD32_SHARE_SUB_EN.
module add32_share_ctrl #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_wide,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [32*NREQ-1:0] req_ah,
  input  logic [32*NREQ-1:0] req_bh,
  input  logic [NREQ-1:0]   req_cin,
`ifdef ADD32_SHARE_SUB_EN
  input  logic [NREQ-1:0]   req_sub,
`endif
  output logic              add_en,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  output logic              add_cin,
  input  logic [31:0]       add_sum,
  input  logic              add_cout,
  input  logic              add_ov,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [63:0]       rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ov
);
  typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;
  state_t state_q;
  logic [IDW-1:0] last_q, gnt, idx;
  logic gnt_any, wide_q;
  logic [NREQ-1:0] sub_v;
  logic [31:0] ah_q, bh_q, add_a_q, add_b_q;
  logic add_en_q, add_cin_q, rsp_valid_q, rsp_cout_q, rsp_ov_q;
  logic [IDW-1:0] rsp_id_q;
  logic [63:0] rsp_sum_q;
`ifdef ADD32_SHARE_SUB_EN
  assign sub_v = req_sub;
`else
  assign sub_v = '0;
`endif
  always_comb begin
    gnt = '0;
    gnt_any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(last_q) + 1 + k) % NREQ);
      if (req_valid[idx]) begin
        gnt = idx;
        gnt_any = 1'b1;
      end
    end
  end
  assign req_ready = (state_q == IDLE && gnt_any) ? NREQ'(1) << gnt : '0;
  assign add_en    = add_en_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ov    = rsp_ov_q;
  // Adder port values are registered one state ahead so they are valid for the whole LO/HI cycle.
  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      wide_q      <= 1'b0;
      ah_q        <= '0;
      bh_q        <= '0;
      add_en_q    <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ov_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (gnt_any) begin
          state_q   <= LO;
          last_q    <= gnt;
          rsp_id_q  <= gnt;
          wide_q    <= req_wide[gnt];
          ah_q      <= req_ah[32*int'(gnt) +: 32];
          bh_q      <= req_bh[32*int'(gnt) +: 32] ^ {32{sub_v[gnt]}};
          add_en_q  <= 1'b1;
          add_a_q   <= req_a[32*int'(gnt) +: 32];
          add_b_q   <= req_b[32*int'(gnt) +: 32] ^ {32{sub_v[gnt]}};
          add_cin_q <= sub_v[gnt] | req_cin[gnt];
        end
        LO: begin
          rsp_sum_q  <= {32'h0, add_sum};
          rsp_cout_q <= add_cout;
          rsp_ov_q   <= add_ov;
          state_q    <= wide_q ? HI : RSP;
          rsp_valid_q <= !wide_q;
          add_en_q   <= wide_q;
          add_a_q    <= wide_q ? ah_q : '0;
          add_b_q    <= wide_q ? bh_q : '0;
          add_cin_q  <= wide_q & add_cout;
        end
        HI: begin
          rsp_sum_q[63:32] <= add_sum;
          rsp_cout_q  <= add_cout;
          rsp_ov_q    <= add_ov;
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          add_en_q    <= 1'b0;
          add_a_q     <= '0;
          add_b_q     <= '0;
          add_cin_q   <= 1'b0;
        end
        RSP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add32_share_ctrl.sv
// tb_add32_share_ctrl: scoreboard bench for add32_share_ctrl with a behavioural add32 and arithmetic reference model.
module tb_add32_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  logic m_clock = 1'b0;
  logic p_reset;
  logic [NREQ-1:0] req_valid, req_ready, req_wide, req_cin;
  logic [32*NREQ-1:0] req_a, req_b, req_ah, req_bh;
`ifdef ADD32_SHARE_SUB_EN
  logic [NREQ-1:0] req_sub;
`endif
  logic add_en, add_cin, add_cout, add_ov;
  logic [31:0] add_a, add_b, add_sum;
  logic rsp_valid, rsp_ready, rsp_cout, rsp_ov;
  logic [IDW-1:0] rsp_id;
  logic [63:0] rsp_sum;

  add32_share_ctrl #(.NREQ(NREQ)) dut (
    .m_clock(m_clock), .p_reset(p_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wide(req_wide),
    .req_a(req_a), .req_b(req_b), .req_ah(req_ah), .req_bh(req_bh), .req_cin(req_cin),
`ifdef ADD32_SHARE_SUB_EN
    .req_sub(req_sub),
`endif
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_ov(add_ov),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ov(rsp_ov)
  );

  // external add32 behaviour
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'h0, add_cin};
  assign add_ov = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

  always #5 m_clock = ~m_clock;
  int cyc = 0;
  always @(posedge m_clock) cyc <= cyc + 1;

  typedef struct {
    int id; bit wide; int acc;
    logic [31:0] alo, blo, ahi, bhi;
    bit cin_lo, cin_hi;
    logic [63:0] sum; bit cout, ov;
  } exp_t;
  exp_t sb[$];
  int dut_gnt[$];
  int checks = 0, fails = 0;
  bit model_idle = 1'b1;
  int model_last = NREQ - 1;
  logic [63:0] last_sum;
  logic last_cout, last_ov;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t model(input int id, input int acc);
    exp_t e;
    logic [63:0] a, b;
    logic [64:0] r;
    logic [32:0] rl;
    bit sub, cin;
    sub = 1'b0;
`ifdef ADD32_SHARE_SUB_EN
    sub = req_sub[id];
`endif
    a = {req_ah[32*id +: 32], req_a[32*id +: 32]};
    b = {req_bh[32*id +: 32], req_b[32*id +: 32]};
    if (sub) b = ~b;
    cin = sub ? 1'b1 : req_cin[id];
    e.id = id; e.wide = req_wide[id]; e.acc = acc;
    e.alo = a[31:0]; e.blo = b[31:0]; e.ahi = a[63:32]; e.bhi = b[63:32];
    rl = {1'b0, a[31:0]} + {1'b0, b[31:0]} + 33'(cin);
    e.cin_lo = cin; e.cin_hi = rl[32];
    if (e.wide) begin
      r = {1'b0, a} + {1'b0, b} + 65'(cin);
      e.sum = r[63:0]; e.cout = r[64];
      e.ov = (a[63] == b[63]) && (r[63] != a[63]);
    end else begin
      e.sum = {32'h0, rl[31:0]}; e.cout = rl[32];
      e.ov = (a[31] == b[31]) && (rl[31] != a[31]);
    end
    return e;
  endfunction

  // monitor: checks grants, adder port use and responses against the queued expectations
  always @(negedge m_clock) begin
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    int due;
    if (!p_reset) begin
      sb.delete();
      model_idle = 1'b1;
      model_last = NREQ - 1;
    end else begin
      exp_rdy = '0;
      if (model_idle)
        for (int k = NREQ - 1; k >= 0; k--)
          if (req_valid[(model_last + 1 + k) % NREQ]) exp_rdy = NREQ'(1) << ((model_last + 1 + k) % NREQ);
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) dut_gnt.push_back(i);
      if (sb.size() > 0) begin
        e = sb[0];
        due = e.acc + (e.wide ? 3 : 2);
        if (cyc == e.acc + 1) begin
          chk("lo_en", 64'(add_en), 64'd1);
          chk("lo_a", 64'(add_a), 64'(e.alo));
          chk("lo_b", 64'(add_b), 64'(e.blo));
          chk("lo_cin", 64'(add_cin), 64'(e.cin_lo));
        end else if (e.wide && cyc == e.acc + 2) begin
          chk("hi_en", 64'(add_en), 64'd1);
          chk("hi_a", 64'(add_a), 64'(e.ahi));
          chk("hi_b", 64'(add_b), 64'(e.bhi));
          chk("hi_cin", 64'(add_cin), 64'(e.cin_hi));
        end else begin
          chk("add_idle_ab", {add_a, add_b}, 64'd0);
          chk("add_idle_ctl", 64'({add_en, add_cin}), 64'd0);
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(cyc >= due));
        if (rsp_valid && cyc >= due) begin
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_sum", rsp_sum, e.sum);
          chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
          chk("rsp_ov", 64'(rsp_ov), 64'(e.ov));
          if (rsp_ready) begin
            last_sum = rsp_sum; last_cout = rsp_cout; last_ov = rsp_ov;
            void'(sb.pop_front());
            model_idle = 1'b1;
          end
        end
      end else begin
        chk("add_idle_ab", {add_a, add_b}, 64'd0);
        chk("add_idle_ctl", 64'({add_en, add_cin}), 64'd0);
        chk("rsp_valid", 64'(rsp_valid), 64'd0);
      end
      if (exp_rdy != '0) begin
        for (int i = 0; i < NREQ; i++)
          if (exp_rdy[i]) begin
            sb.push_back(model(i, cyc));
            model_last = i;
          end
        model_idle = 1'b0;
      end
    end
  end

  task automatic set_op(input int id, input bit wide, input logic [63:0] a, input logic [63:0] b,
                        input bit cin, input bit sub);
    req_a[32*id +: 32] = a[31:0];  req_ah[32*id +: 32] = a[63:32];
    req_b[32*id +: 32] = b[31:0];  req_bh[32*id +: 32] = b[63:32];
    req_wide[id] = wide; req_cin[id] = cin;
`ifdef ADD32_SHARE_SUB_EN
    req_sub[id] = sub;
`else
    if (sub) req_cin[id] = cin;
`endif
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_accept(input int id);
    for (int t = 0; t < 100; t++) begin
      @(negedge m_clock);
      if (req_ready[id]) begin
        @(posedge m_clock); #1;
        req_valid[id] = 1'b0;
        return;
      end
    end
    checks++; fails++;
    $display("FAIL accept_timeout id=%0d: got no req_ready want req_ready", id);
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(posedge m_clock); #1;
      if (sb.size() == 0) return;
    end
    checks++; fails++;
    $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
  endtask

  task automatic pulse_reset();
    p_reset = 1'b0;
    @(posedge m_clock); #1;
    p_reset = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt[NREQ];
    int total;
    int e5[5];
    logic [NREQ-1:0] acc;
    e5 = '{0, 1, 2, 3, 0};
    p_reset = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_wide = '0; req_cin = '0;
    req_a = '0; req_b = '0; req_ah = '0; req_bh = '0;
`ifdef ADD32_SHARE_SUB_EN
    req_sub = '0;
`endif
    @(posedge m_clock);
    @(negedge m_clock);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_add", {add_a, add_b}, 64'd0);
    chk("reset_ctl", 64'({add_en, add_cin, rsp_valid, rsp_cout, rsp_ov, rsp_id}), 64'd0);
    chk("reset_sum", rsp_sum, 64'd0);
    @(posedge m_clock); #1;
    p_reset = 1'b1;
    // directed ops
    set_op(0, 0, 64'h5, 64'h3, 0, 0); wait_accept(0); drain();
    chk("t1_sum", last_sum, 64'h8);
    set_op(1, 0, 64'h7FFF_FFFF, 64'h1, 0, 0); wait_accept(1); drain();
    chk("t2_sum", last_sum, 64'h8000_0000);
    chk("t2_ov", 64'(last_ov), 64'd1);
    set_op(2, 1, 64'h1_FFFF_FFFF, 64'h1, 0, 0); wait_accept(2); drain();
    chk("t3_sum", last_sum, 64'h2_0000_0000);
    // all requesters contending from a fresh priority pointer
    pulse_reset();
    dut_gnt.delete();
    total = 0;
    for (int i = 0; i < NREQ; i++) begin cnt[i] = 0; set_op(i, 1'($urandom), rnd64(), rnd64(), 1'($urandom), 0); end
    for (int t = 0; t < 200 && total < 2 * NREQ; t++) begin
      @(negedge m_clock);
      acc = req_valid & req_ready;
      @(posedge m_clock); #1;
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) begin
          cnt[i]++; total++;
          if (cnt[i] < 2) set_op(i, 1'($urandom), rnd64(), rnd64(), 1'($urandom), 0);
          else req_valid[i] = 1'b0;
        end
    end
    drain();
    for (int i = 0; i < 5; i++) chk("grant_order", 64'(dut_gnt.size() > i ? dut_gnt[i] : -1), 64'(e5[i]));
    // response backpressure with a competing request
    rsp_ready = 1'b0;
    set_op(3, 0, rnd64(), rnd64(), 1, 0); wait_accept(3);
    set_op(0, 1, rnd64(), rnd64(), 0, 0);
    repeat (6) @(posedge m_clock);
    #1 rsp_ready = 1'b1;
    wait_accept(0); drain();
    // reset during the high pass drops the op
    set_op(2, 1, rnd64(), rnd64(), 1, 0); wait_accept(2);
    @(posedge m_clock); #1;
    p_reset = 1'b0;
    @(posedge m_clock); #1;
    p_reset = 1'b1;
    dut_gnt.delete();
    set_op(1, 0, rnd64(), rnd64(), 0, 0);
    set_op(0, 0, rnd64(), rnd64(), 0, 0);
    wait_accept(0);
    chk("post_reset_gnt", 64'(dut_gnt.size() > 0 ? dut_gnt[0] : -1), 64'd0);
    wait_accept(1); drain();
`ifdef ADD32_SHARE_SUB_EN
    set_op(1, 0, 64'h3, 64'h5, 0, 1); wait_accept(1); drain();
    chk("sub_3_5", 64'(last_sum[31:0]), 64'hFFFF_FFFE);
    set_op(3, 1, 64'h1_0000_0000, 64'h1, 1, 1); wait_accept(3); drain();
    chk("sub_wide", last_sum, 64'h0_FFFF_FFFF);
`endif
    // randomized traffic with random response backpressure
    for (int n = 0; n < 40; n++) begin
      int id;
      logic [63:0] a, b;
      id = $urandom_range(0, NREQ - 1);
      a = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : rnd64();
      b = ($urandom_range(0, 3) == 0) ? 64'h7FFF_FFFF_7FFF_FFFF : rnd64();
      set_op(id, 1'($urandom), a, b, 1'($urandom), 1'($urandom));
      wait_accept(id);
      for (int t = 0; t < 100 && sb.size() > 0; t++) begin
        rsp_ready = 1'($urandom);
        @(posedge m_clock); #1;
      end
      rsp_ready = 1'b1;
      drain();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
